// File: rtl/heartbeat_pkg.sv
// Shared types and defaults for the heartbeat reporter: the report record,
// default parameter values and the period-boundary helper.
package heartbeat_pkg;

  localparam int HB_WIDTH  = 32;
  localparam int HB_PERIOD = 200000;
  localparam int HB_LIMIT  = 1000000;
  localparam int HB_DEPTH  = 4;
  localparam int HB_DROP_W = 16;

  typedef struct packed {
    logic [HB_WIDTH-1:0] cnt;
    logic                last;
  } hb_rec_t;

  // phase tracks count mod period, so the next count is a multiple of period
  // exactly when phase sits on its last value.
  function automatic logic hb_is_period(input logic [HB_WIDTH-1:0] phase,
                                        input logic [HB_WIDTH-1:0] period);
    return phase == (period - HB_WIDTH'(1));
  endfunction

endpackage

// File: rtl/hb_fifo.sv
// Synchronous show-ahead FIFO of report records. head is the oldest entry,
// or all zeros when empty. Push and pop on the same edge is legal when full.
module hb_fifo
  import heartbeat_pkg::*;
#(
  parameter int DEPTH = HB_DEPTH
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  hb_rec_t push_data,
  input  logic    pop,
  output hb_rec_t head,
  output logic    empty,
  output logic    full
);

  localparam int AW = $clog2(DEPTH);

  hb_rec_t        mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    used;
  logic           do_push;
  logic           do_pop;

  assign empty   = (used == '0);
  assign full    = (used == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   used <= used + (AW+1)'(1);
        2'b01:   used <= used - (AW+1)'(1);
        default: used <= used;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/heartbeat_reporter.sv
// Cycle-count heartbeat: counts enabled cycles up to LIMIT, queues a record
// every PERIOD cycles plus a terminal record, and flags done once it drains.
module heartbeat_reporter
  import heartbeat_pkg::*;
#(
  parameter int WIDTH  = HB_WIDTH,
  parameter int PERIOD = HB_PERIOD,
  parameter int LIMIT  = HB_LIMIT,
  parameter int DEPTH  = HB_DEPTH,
  parameter int DROP_W = HB_DROP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_cnt,
  output logic              out_last,
  output logic              done,
  output logic [DROP_W-1:0] dropped,
  output logic [WIDTH-1:0]  count
);

  localparam logic [WIDTH-1:0] LIMIT_V     = WIDTH'(LIMIT);
  localparam logic [WIDTH-1:0] PHASE_MAX_V = WIDTH'(PERIOD - 1);

  logic [WIDTH-1:0] phase;
  logic [WIDTH-1:0] cnt_next;
  logic             cnt_en;
  logic             period_evt;
  logic             hit_limit;
  logic             push_req;
  logic             pop;
  logic             space;
  logic             fifo_push;
  logic             fifo_empty;
  logic             fifo_full;
  logic             pend_last;
  hb_rec_t          push_rec;
  hb_rec_t          head;

  assign cnt_en     = en && (count != LIMIT_V);
  assign cnt_next   = count + WIDTH'(1);
  assign period_evt = cnt_en && hb_is_period(HB_WIDTH'(phase), HB_WIDTH'(PERIOD));
  assign hit_limit  = cnt_en && (cnt_next == LIMIT_V);
  assign push_req   = period_evt || hit_limit;

  // Handshake: a record transfers on a rising edge with out_valid && out_ready;
  // out_valid/out_cnt/out_last hold while out_valid is high and out_ready low.
  assign pop       = out_valid && out_ready;
  assign space     = !fifo_full || pop;
  assign fifo_push = (pend_last || push_req) && space;

  always_comb begin
    push_rec = '0;
    if (pend_last) begin
      push_rec.cnt  = HB_WIDTH'(LIMIT_V);
      push_rec.last = 1'b1;
    end else begin
      push_rec.cnt  = HB_WIDTH'(cnt_next);
      push_rec.last = hit_limit;
    end
  end

  hb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (push_rec),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign out_valid = !fifo_empty;
  assign out_cnt   = head.cnt[WIDTH-1:0];
  assign out_last  = head.last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      phase     <= '0;
      pend_last <= 1'b0;
      dropped   <= '0;
      done      <= 1'b0;
    end else begin
      if (cnt_en) begin
        count <= cnt_next;
        phase <= (phase == PHASE_MAX_V) ? '0 : phase + WIDTH'(1);
      end
      // The terminal record waits here for space; counting has stopped by then.
      if (pend_last && space)
        pend_last <= 1'b0;
      else if (hit_limit && !space)
        pend_last <= 1'b1;
      if (period_evt && !hit_limit && !space && (dropped != '1))
        dropped <= dropped + DROP_W'(1);
      if (pop && head.last)
        done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_heartbeat_reporter.sv
// Bench for heartbeat_reporter: directed scenarios plus randomized en/ready
// traffic, checked every cycle against a queue-based reference model.
module tb_heartbeat_reporter;

  localparam int W      = 32;
  localparam int DW     = 16;
  localparam int PERIOD = 4;
  localparam int LIMIT  = 13;
  localparam int DEPTH  = 2;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_cnt;
  logic          out_last;
  logic          done;
  logic [DW-1:0] dropped;
  logic [W-1:0]  count;

  heartbeat_reporter #(
    .WIDTH (W), .PERIOD(PERIOD), .LIMIT(LIMIT), .DEPTH(DEPTH), .DROP_W(DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_cnt   (out_cnt),
    .out_last  (out_last),
    .done      (done),
    .dropped   (dropped),
    .count     (count)
  );

  typedef struct packed {
    logic [W-1:0] cnt;
    logic         last;
  } mrec_t;

  mrec_t       m_q[$];
  int unsigned m_count;
  bit          m_pend;
  bit          m_done;
  int unsigned m_dropped;
  logic [W:0]  got_q[$];
  int          total;
  int          bad;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [W:0] rec(input int unsigned c, input bit l);
    return {W'(c), l};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_count   = 0;
    m_pend    = 0;
    m_done    = 0;
    m_dropped = 0;
  endtask

  // One rising edge of the reference: pop first (a pop frees a slot for this
  // edge's push), then the pending terminal record or the new count's record.
  task automatic model_step();
    int    sz;
    bit    popped;
    bit    room;
    mrec_t r;
    sz     = m_q.size();
    popped = (sz > 0) && out_ready;
    room   = (sz < DEPTH) || popped;
    if (popped) begin
      if (m_q[0].last) m_done = 1;
      void'(m_q.pop_front());
    end
    if (m_pend) begin
      if (room) begin
        r.cnt  = W'(LIMIT);
        r.last = 1'b1;
        m_q.push_back(r);
        m_pend = 0;
      end
    end else if (en && m_count != LIMIT) begin
      m_count++;
      if ((m_count % PERIOD) == 0 || m_count == LIMIT) begin
        r.cnt  = W'(m_count);
        r.last = (m_count == LIMIT);
        if (room)                  m_q.push_back(r);
        else if (r.last)           m_pend = 1;
        else if (m_dropped < 65535) m_dropped++;
      end
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", out_valid, m_q.size() > 0);
    chk("out_cnt",   out_cnt,   m_q.size() > 0 ? m_q[0].cnt : '0);
    chk("out_last",  out_last,  m_q.size() > 0 ? m_q[0].last : 1'b0);
    chk("done",      done,      m_done);
    chk("dropped",   dropped,   m_dropped);
    chk("count",     count,     m_count);
  endtask

  // Called at a falling edge: drive inputs for the next rising edge.
  task automatic tick(input logic e, input logic r);
    en        = e;
    out_ready = r;
    if (out_valid && r) got_q.push_back({out_cnt, out_last});
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  // Reset asserted between edges; state must clear before any clock edge.
  task automatic async_reset();
    en        = 1'b0;
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    got_q.delete();
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_cnt",   out_cnt,   0);
    chk("rst_out_last",  out_last,  0);
    chk("rst_done",      done,      0);
    chk("rst_dropped",   dropped,   0);
    chk("rst_count",     count,     0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && !done; i++) tick(1'b1, 1'b1);
    chk("done_reached", done, 1);
  endtask

  task automatic wait_count(input int unsigned target, input logic e, input logic r,
                            input int budget);
    for (int i = 0; i < budget && count != target; i++) tick(e, r);
    chk("reach_count", count, target);
  endtask

  task automatic expect_log(input string nm, input int n, input logic [W:0] e0,
                            input logic [W:0] e1, input logic [W:0] e2, input logic [W:0] e3);
    logic [W:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    chk({nm, "_len"}, got_q.size(), n);
    for (int i = 0; i < n; i++)
      chk(nm, i < got_q.size() ? got_q[i] : '1, e[i]);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    en        = 1'b0;
    out_ready = 1'b0;
    model_reset();
    @(negedge clk);

    // Free-running: every record delivered, terminal record not a period multiple.
    async_reset();
    drain(40);
    expect_log("log_free", 4, rec(4, 0), rec(8, 0), rec(12, 0), rec(13, 1));
    chk("free_count", count, 13);
    chk("free_dropped", dropped, 0);
    repeat (3) tick(1'b1, 1'b1);

    // Consumer stalled: 12 is dropped, 13 waits for space.
    async_reset();
    repeat (20) tick(1'b1, 1'b0);
    chk("stall_dropped", dropped, 1);
    drain(40);
    expect_log("log_stall", 3, rec(4, 0), rec(8, 0), rec(13, 1), '0);

    // Enable held low mid-run: values unchanged, count frozen.
    async_reset();
    wait_count(5, 1'b1, 1'b1, 20);
    repeat (5) begin
      tick(1'b0, 1'b1);
      chk("en_low_count", count, 5);
    end
    drain(40);
    expect_log("log_en", 4, rec(4, 0), rec(8, 0), rec(12, 0), rec(13, 1));

    // Full FIFO with a pop on the push edge: no drop.
    async_reset();
    wait_count(11, 1'b1, 1'b0, 30);
    tick(1'b1, 1'b1);
    repeat (4) tick(1'b1, 1'b0);
    chk("pop_on_push_dropped", dropped, 0);
    drain(40);
    expect_log("log_full_pop", 4, rec(4, 0), rec(8, 0), rec(12, 0), rec(13, 1));

    // Reset in flight with a record queued, then restart from zero.
    async_reset();
    wait_count(7, 1'b1, 1'b0, 20);
    chk("queued_before_reset", out_valid, 1);
    async_reset();
    for (int i = 0; i < 20 && got_q.size() == 0; i++) tick(1'b1, 1'b1);
    chk("first_after_reset", got_q.size() > 0 ? got_q[0] : '1, rec(4, 0));

    // Randomized enable and consumer traffic.
    for (int run = 0; run < 8; run++) begin
      int unsigned thr;
      int unsigned n;
      async_reset();
      thr = $urandom_range(0, 3);
      n   = $urandom_range(10, 50);
      repeat (n) tick($urandom_range(0, 3) != 0, $urandom_range(0, 2) < thr);
      drain(60);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
